// File: rtl/led_pulse_stretch_pkg.sv
// led_pulse_pkg: channel state encoding and default widths shared by led_pulse_stretch.
package led_pulse_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FADE = 2'd2} state_t;
    localparam int def_bw_hold = 4;
    localparam int def_bw_pwm = 4;
endpackage

// File: rtl/led_pulse_stretch_if.sv
// led_pulse_stretch_if: frame strobe, trigger pulses and LED/busy outputs of led_pulse_stretch.
interface led_pulse_stretch_if #(parameter int num_led = 1);
    logic Frame;
    logic [num_led-1:0] Trig;
    logic [num_led-1:0] Led;
    logic [num_led-1:0] Busy;
    modport master(output Frame, Trig, input Led, Busy);
    modport slave(input Frame, Trig, output Led, Busy);
endinterface

// File: rtl/led_pulse_stretch_chan.sv
// led_pulse_chan: one LED channel, hold on for hold_frames Frames then (LED_PULSE_FADE_EN) fade out by PWM.
module led_pulse_chan
    import led_pulse_pkg::*;
#(
    parameter int bw_hold = def_bw_hold,
`ifdef LED_PULSE_FADE_EN
    parameter int bw_pwm = def_bw_pwm,
`endif
    parameter int hold_frames = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Frame,
    input  logic Trig,
`ifdef LED_PULSE_FADE_EN
    input  logic [bw_pwm-1:0] pwm_cnt,
`endif
    output logic Led,
    output logic Busy
);
    state_t state;
    logic [bw_hold-1:0] cnt;
`ifdef LED_PULSE_FADE_EN
    logic [bw_pwm-1:0] lvl;
    logic [bw_pwm-1:0] lvl_dec;
    logic [bw_pwm-1:0] pwm_nxt;
    // Led is registered, so compare against the PWM value it will be shown alongside
    assign pwm_nxt = pwm_cnt + bw_pwm'(1);
    assign lvl_dec = lvl - bw_pwm'(1);
`endif
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
            Led <= 1'b0;
            Busy <= 1'b0;
`ifdef LED_PULSE_FADE_EN
            lvl <= '0;
`endif
        end else if (Trig) begin
            state <= HOLD;
            cnt <= bw_hold'(hold_frames);
            Led <= 1'b1;
            Busy <= 1'b1;
        end else if (state == HOLD && Frame) begin
            cnt <= cnt - bw_hold'(1);
            if (cnt == bw_hold'(1)) begin
`ifdef LED_PULSE_FADE_EN
                state <= FADE;
                lvl <= '1;
                Led <= pwm_nxt != '1;
`else
                state <= IDLE;
                Led <= 1'b0;
                Busy <= 1'b0;
`endif
            end
`ifdef LED_PULSE_FADE_EN
        end else if (state == FADE) begin
            if (Frame) begin
                lvl <= lvl_dec;
                state <= lvl == bw_pwm'(1) ? IDLE : FADE;
                Busy <= lvl != bw_pwm'(1);
                Led <= pwm_nxt < lvl_dec;
            end else begin
                Led <= pwm_nxt < lvl;
            end
`endif
        end
    end
endmodule

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: stretches event pulses into visible LED indications; LED_PULSE_FADE_EN adds the PWM fade-out.
module led_pulse_stretch
    import led_pulse_pkg::*;
#(
    parameter int num_led = 1,
    parameter int bw_hold = def_bw_hold,
    parameter int hold_frames = 8,
    parameter int bw_pwm = def_bw_pwm
) (
    input logic Clock,
    input logic Reset,
    led_pulse_stretch_if.slave bus
);
    if (hold_frames < 1 || hold_frames >= 2 ** bw_hold || bw_pwm < 1) begin : g_bad_param
        $error("led_pulse_stretch: illegal parameter set");
    end
`ifdef LED_PULSE_FADE_EN
    logic [bw_pwm-1:0] pwm_cnt;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + bw_pwm'(1);
    end
`endif
    for (genvar g = 0; g < num_led; g++) begin : g_chan
        led_pulse_chan #(
            .bw_hold(bw_hold),
`ifdef LED_PULSE_FADE_EN
            .bw_pwm(bw_pwm),
`endif
            .hold_frames(hold_frames)
        ) u_chan (
            .Clock(Clock),
            .Reset(Reset),
            .Frame(bus.Frame),
            .Trig(bus.Trig[g]),
`ifdef LED_PULSE_FADE_EN
            .pwm_cnt(pwm_cnt),
`endif
            .Led(bus.Led[g]),
            .Busy(bus.Busy[g])
        );
    end
endmodule

// File: tb/tb_led_pulse_stretch.sv
// tb_led_pulse_stretch: randomized and directed checks of led_pulse_stretch against a frame-count reference model.
module tb_led_pulse_stretch;
    localparam int hold = 3;
    localparam int pwm_max = 3;
`ifdef LED_PULSE_FADE_EN
    localparam int fade_len = pwm_max;
`else
    localparam int fade_len = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int fcnt = 0;
    int pwm_m = 0;
    bit act [2];
    int since [2];
    led_pulse_stretch_if #(.num_led(2)) bus ();
    led_pulse_stretch #(.num_led(2), .bw_hold(4), .hold_frames(hold), .bw_pwm(2)) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    // A lit channel is in HOLD for its first `hold` Frames after the last Trig, then fades one level per Frame
    function automatic logic [1:0] exp_led();
        logic [1:0] r = '0;
        for (int i = 0; i < 2; i++)
            if (act[i]) r[i] = since[i] < hold ? 1'b1 : (pwm_m < pwm_max - (since[i] - hold));
        return r;
    endfunction
    task automatic model_clear();
        pwm_m = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            since[i] = 0;
        end
    endtask
    task automatic step(input logic [1:0] t);
        bus.Frame = (fcnt == 7);
        bus.Trig = t;
        @(posedge clk);
        fcnt = (fcnt + 1) % 8;
        pwm_m = (pwm_m + 1) % (pwm_max + 1);
        for (int i = 0; i < 2; i++) begin
            if (t[i]) begin
                act[i] = 1'b1;
                since[i] = 0;
            end else if (act[i] && bus.Frame) begin
                since[i]++;
                if (since[i] >= hold + fade_len) act[i] = 1'b0;
            end
        end
        #1;
        check("led", 32'(bus.Led), 32'(exp_led()));
        check("busy", 32'(bus.Busy), {30'd0, act[1], act[0]});
        @(negedge clk);
    endtask
    task automatic frame_step(input logic [1:0] t);
        while (fcnt != 7) step(2'b00);
        step(t);
    endtask
    initial begin
        bus.Frame = 1'b0;
        bus.Trig = 2'b00;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", 32'(bus.Led), 32'd0);
        check("reset_busy", 32'(bus.Busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) step(2'b00);
        step(2'b01);
        repeat (60) step(2'b00);
        step(2'b01);
        frame_step(2'b00);
        frame_step(2'b00);
        frame_step(2'b01);
        check("retrig_on_frame", {31'd0, act[0]}, 32'd1);
        repeat (60) step(2'b00);
        step(2'b10);
        repeat (hold + fade_len - 1) frame_step(2'b00);
        step(2'b10);
        check("retrig_fade", {31'd0, bus.Led[1]}, 32'd1);
        repeat (60) step(2'b00);
        step(2'b11);
        repeat (10) step(2'b00);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", 32'(bus.Led), 32'd0);
        check("async_rst_busy", 32'(bus.Busy), 32'd0);
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) step(2'b00);
        repeat (1500) step({$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0});
        repeat (80) step(2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
